// File: rtl/instruction_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with cache
// handshakes, one-cycle enable strobes, retire counter and memory timeout.
module instruction_sequencer #(
    parameter int COUNT_WIDTH = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   run,
    input  logic                   fetchAck,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic                   regWriteFlag,
    input  logic                   branch,
    input  logic                   unconditionalBranch,
    input  logic                   zeroFlag,
    input  logic                   memAck,
    output logic                   fetchReq,
    output logic                   irLoad,
    output logic                   aluEnable,
    output logic                   memReadEn,
    output logic                   memWriteEn,
    output logic                   regWriteEn,
    output logic                   pcWrite,
    output logic                   pcBranchSel,
    output logic [2:0]             stage,
    output logic                   busy,
    output logic                   memError,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXE   = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_ERR   = 3'd6,
        S_BAD   = 3'd7
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;
    logic                   reg_wr_q, reg_wr_d;
    logic                   br_q, br_d;
    logic                   ubr_q, ubr_d;
    logic                   zero_q, zero_d;
    logic [7:0]             wait_q, wait_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   retire;
    logic                   zero_now;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            reg_wr_q <= 1'b0;
            br_q     <= 1'b0;
            ubr_q    <= 1'b0;
            zero_q   <= 1'b0;
            wait_q   <= 8'd0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            reg_wr_q <= reg_wr_d;
            br_q     <= br_d;
            ubr_q    <= ubr_d;
            zero_q   <= zero_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        reg_wr_d    = reg_wr_q;
        br_d        = br_q;
        ubr_d       = ubr_q;
        zero_d      = zero_q;
        wait_d      = wait_q;
        count_d     = count_q;
        retire      = 1'b0;
        fetchReq    = 1'b0;
        irLoad      = 1'b0;
        aluEnable   = 1'b0;
        memReadEn   = 1'b0;
        memWriteEn  = 1'b0;
        regWriteEn  = 1'b0;
        pcWrite     = 1'b0;
        pcBranchSel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                fetchReq = 1'b1;
                if (fetchAck) begin
                    irLoad  = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                mem_rd_d = memRead;
                mem_wr_d = memWrite;
                reg_wr_d = regWriteFlag;
                br_d     = branch;
                ubr_d    = unconditionalBranch;
                state_d  = (memRead && memWrite) ? S_ERR : S_EXE;
            end
            S_EXE: begin
                aluEnable = 1'b1;
                zero_d    = zeroFlag;
                if (mem_rd_q || mem_wr_q) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else if (reg_wr_q) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                memReadEn  = mem_rd_q;
                memWriteEn = mem_wr_q;
                // wait_q holds the number of MEMORY cycles already spent
                if (memAck) begin
                    if (mem_rd_q && reg_wr_q) state_d = S_WB;
                    else                      retire  = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                regWriteEn = 1'b1;
                retire     = 1'b1;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A branch retiring in EXECUTE sees the live zero flag
        zero_now = (state_q == S_EXE) ? zeroFlag : zero_q;

        if (retire) begin
            pcWrite     = 1'b1;
            pcBranchSel = ubr_q | (br_q & zero_now);
            count_d     = count_q + COUNT_WIDTH'(1);
            state_d     = run ? S_FETCH : S_IDLE;
        end
    end

    assign stage        = state_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_ERR);
    assign memError     = (state_q == S_ERR);
    assign retiredCount = count_q;

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Multi-cycle stage sequencer for the ARM-LP datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and handshakes with the instruction and data caches. It samples the decoded control flags and converts them into one-cycle enable strobes for the instruction register, ALU, data cache, register file and PC. It also keeps a retired-instruction count and a sticky memory-timeout error.

Parameters:
COUNT_WIDTH, 32, width of retiredCount (wraps modulo 2^COUNT_WIDTH)
MEM_TIMEOUT, 15, max MEMORY-stage cycles without memAck before ERROR (legal range 1..255)

Ports:
clock  input  1  main clock, rising edge
resetN  input  1  reset, asynchronous, active-low
run  input  1  level; high = keep issuing instructions, low = stop at next instruction boundary
fetchAck  input  1  instruction cache: instruction valid this cycle
memRead  input  1  decoded flag, sampled in DECODE
memWrite  input  1  decoded flag, sampled in DECODE
regWriteFlag  input  1  decoded flag, sampled in DECODE
branch  input  1  decoded conditional-branch flag, sampled in DECODE
unconditionalBranch  input  1  decoded flag, sampled in DECODE
zeroFlag  input  1  ALU zero result, sampled in EXECUTE
memAck  input  1  data cache: access complete this cycle
fetchReq  output  1  instruction fetch request, high throughout FETCH
irLoad  output  1  load instruction register; equals (state==FETCH & fetchAck)
aluEnable  output  1  high for the single EXECUTE cycle
memReadEn  output  1  high throughout MEMORY when latched memRead
memWriteEn  output  1  high throughout MEMORY when latched memWrite
regWriteEn  output  1  high for the single WRITEBACK cycle
pcWrite  output  1  one-cycle strobe on the retire cycle
pcBranchSel  output  1  valid with pcWrite; 1 = take branch target
stage  output  3  current state encoding
busy  output  1  state not IDLE and not ERROR
memError  output  1  sticky; high while in ERROR
retiredCount  output  COUNT_WIDTH  number of instructions retired

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6. Value 7 is unreachable and recovers to IDLE.
- Reset (resetN low, any time, including mid-instruction):
  - state goes to IDLE immediately.
  - All latched flags, the wait counter, retiredCount and memError clear to 0.
  - All outputs read 0, stage reads 0.
- Strobes are decoded from registered state plus inputs; none is registered separately.
- IDLE: if run, next state is FETCH. fetchAck and memAck are ignored.
- FETCH: fetchReq=1. On fetchAck, irLoad=1 and next state is DECODE; otherwise stay in FETCH indefinitely (no timeout).
- DECODE: latch memRead, memWrite, regWriteFlag, branch and unconditionalBranch.
  - If memRead and memWrite are both 1, next state is ERROR.
  - Otherwise next state is EXECUTE.
- EXECUTE: aluEnable=1 and zeroFlag is latched. Next state:
  - latched memRead or memWrite: MEMORY, wait counter cleared.
  - else latched regWriteFlag: WRITEBACK.
  - else: retire.
- MEMORY: memReadEn or memWriteEn asserted per latched flag.
  - memAck in MEMORY cycle k, with 1<=k<=MEM_TIMEOUT, completes the access. If latched memRead and regWriteFlag, next state is WRITEBACK; otherwise retire in this cycle.
  - No memAck in cycles 1..MEM_TIMEOUT: next state is ERROR.
- WRITEBACK: regWriteEn=1, then retire.
- Retire cycle:
  - pcWrite=1.
  - pcBranchSel = latched unconditionalBranch | (latched branch & latched zero).
  - retiredCount increments, wrapping from all-ones to 0.
  - Next state is FETCH if run, else IDLE. run is sampled only here and in IDLE; deasserting it mid-instruction never aborts the instruction.
- ERROR: all enables 0, busy=0, memError=1. Exit only via resetN.
- Latency with immediate acks:
  - branch / no-op: 3 cycles (FETCH, DECODE, EXECUTE).
  - R-type: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
  - memory waits add cycles one-for-one.
- Back-to-back: the cycle after a retire is FETCH, giving no bubble.

Test Plan:
- Reset mid-MEMORY: assert resetN=0 during a load's memory wait → stage=0, all strobes 0, retiredCount=0 asynchronously (before next clock edge).
- R-type with run=1, fetchAck=1 and regWriteFlag=1 only → stage sequence 1,2,3,5; regWriteEn and pcWrite high in cycle 4, pcBranchSel=0; retiredCount goes 0→1.
- Conditional branch (branch=1) run twice:
  - zeroFlag=1 → 3-cycle instruction, pcWrite and pcBranchSel both 1 in the EXECUTE cycle.
  - zeroFlag=0 → pcBranchSel=0.
- Load with memAck delayed to MEMORY cycle 15 (MEM_TIMEOUT=15) → completes, WRITEBACK follows, memError=0.
- Same load with no memAck → ERROR after 15 MEMORY cycles; stage=6, memError=1, busy=0; held until reset.
- Illegal flags memRead=memWrite=1 → ERROR directly from DECODE.
- run dropped during EXECUTE of a store → store completes (memWriteEn until memAck), pcWrite pulses, then stage=0.
- retiredCount wrap with COUNT_WIDTH=4 → 16 retirements return it to 0.
